// File: rtl/salsa_stream_cipher.sv
// Salsa20/20 stream cipher: iterative keystream block generator plus
// 32-bit XOR data path with auto-incrementing 64-bit block counter.
// Ports: clk, rst_n (async low); start, key_in[255:0], nonce_in[63:0],
//   counter_in[63:0] load a new stream; in_valid/in_ready/in_data and
//   out_valid/out_ready/out_data form the data path; busy, counter_out,
//   cnt_err report status.
// Param DR_PER_CYCLE (1,2,5,10): double rounds chained per GEN cycle.
// Optional macro SALSA_CNT_WRAP_ERR_EN: stop with sticky cnt_err at
//   counter exhaustion instead of wrapping.

module salsa_double_round (
  input  logic [511:0] x_i,
  output logic [511:0] x_o
);

  function automatic logic [31:0] rotl(
    input logic [31:0] v,
    input int          s
  );
    return (v << s) | (v >> (32 - s));
  endfunction

  // Returns {d', c', b', a'}
  function automatic logic [127:0] qr(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d
  );
    logic [31:0] a1, b1, c1, d1;
    b1 = b ^ rotl(a + d, 7);
    c1 = c ^ rotl(b1 + a, 9);
    d1 = d ^ rotl(c1 + b1, 13);
    a1 = a ^ rotl(d1 + c1, 18);
    return {d1, c1, b1, a1};
  endfunction

  logic [31:0] y [16];
  logic [31:0] z [16];
  logic [31:0] w [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      y[i] = x_i[32*i +: 32];
    end
    // column round
    {z[12], z[8],  z[4],  z[0]}  = qr(y[0],  y[4],  y[8],  y[12]);
    {z[1],  z[13], z[9],  z[5]}  = qr(y[5],  y[9],  y[13], y[1]);
    {z[6],  z[2],  z[14], z[10]} = qr(y[10], y[14], y[2],  y[6]);
    {z[11], z[7],  z[3],  z[15]} = qr(y[15], y[3],  y[7],  y[11]);
    // row round
    {w[3],  w[2],  w[1],  w[0]}  = qr(z[0],  z[1],  z[2],  z[3]);
    {w[4],  w[7],  w[6],  w[5]}  = qr(z[5],  z[6],  z[7],  z[4]);
    {w[9],  w[8],  w[11], w[10]} = qr(z[10], z[11], z[8],  z[9]);
    {w[14], w[13], w[12], w[15]} = qr(z[15], z[12], z[13], z[14]);
    x_o = '0;
    for (int i = 0; i < 16; i++) begin
      x_o[32*i +: 32] = w[i];
    end
  end

endmodule

module salsa_stream_cipher #(
  parameter int DR_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [63:0]  nonce_in,
  input  logic [63:0]  counter_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         busy,
  output logic [63:0]  counter_out,
  output logic         cnt_err
);

  localparam int         N    = 10 / DR_PER_CYCLE;
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_STREAM
  } st_e;

  function automatic logic [511:0] init_fn(
    input logic [255:0] k,
    input logic [63:0]  n,
    input logic [63:0]  c
  );
    return {32'h6b206574, k[255:128], 32'h79622d32, c, n,
            32'h3320646e, k[127:0], 32'h61707865};
  endfunction

  function automatic logic [511:0] add16(
    input logic [511:0] a,
    input logic [511:0] b
  );
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return r;
  endfunction

  st_e          fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   widx_q, widx_d;
  logic [255:0] key_q, key_d;
  logic [63:0]  nonce_q, nonce_d;
  logic [63:0]  cnt_q, cnt_d;
  logic [511:0] work_q, work_d;
  logic [511:0] ks_q, ks_d;
  logic         ov_q, ov_d;
  logic [31:0]  od_q, od_d;
`ifdef SALSA_CNT_WRAP_ERR_EN
  logic         err_q, err_d;
`endif

  logic [DR_PER_CYCLE:0][511:0] chain;
  logic [63:0]  cnt_inc;
  logic [511:0] init_cur;
  logic         in_fire;

  assign chain[0] = work_q;

  for (genvar g = 0; g < DR_PER_CYCLE; g++) begin : g_dr
    salsa_double_round u_dr (
      .x_i (chain[g]),
      .x_o (chain[g+1])
    );
  end

  assign cnt_inc  = cnt_q + 64'd1;
  assign init_cur = init_fn(key_q, nonce_q, cnt_q);
  assign in_ready = (fsm_q == ST_STREAM) && (!ov_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    widx_d  = widx_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    ks_d    = ks_q;
    ov_d    = ov_q;
    od_d    = od_q;
`ifdef SALSA_CNT_WRAP_ERR_EN
    err_d   = err_q;
`endif
    // pending word drains in any state
    if (ov_q && out_ready) ov_d = 1'b0;
    if (start) begin
      key_d   = key_in;
      nonce_d = nonce_in;
      cnt_d   = counter_in;
      work_d  = init_fn(key_in, nonce_in, counter_in);
      round_d = '0;
      widx_d  = '0;
      ov_d    = 1'b0;
      fsm_d   = ST_GEN;
`ifdef SALSA_CNT_WRAP_ERR_EN
      err_d   = 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        ST_IDLE: fsm_d = ST_IDLE;
        ST_GEN: begin
          work_d  = chain[DR_PER_CYCLE];
          round_d = round_q + 4'd1;
          if (round_q == LAST) begin
            ks_d    = add16(chain[DR_PER_CYCLE], init_cur);
            round_d = '0;
            widx_d  = '0;
            fsm_d   = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (in_fire) begin
            od_d   = in_data ^ ks_q[32*widx_q +: 32];
            ov_d   = 1'b1;
            widx_d = widx_q + 4'd1;
            if (widx_q == 4'd15) begin
`ifdef SALSA_CNT_WRAP_ERR_EN
              if (&cnt_q) begin
                err_d = 1'b1;
                fsm_d = ST_IDLE;
              end else begin
                cnt_d   = cnt_inc;
                work_d  = init_fn(key_q, nonce_q, cnt_inc);
                round_d = '0;
                fsm_d   = ST_GEN;
              end
`else
              cnt_d   = cnt_inc;
              work_d  = init_fn(key_q, nonce_q, cnt_inc);
              round_d = '0;
              fsm_d   = ST_GEN;
`endif
            end
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      round_q <= '0;
      widx_q  <= '0;
      key_q   <= '0;
      nonce_q <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      ks_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
`ifdef SALSA_CNT_WRAP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      widx_q  <= widx_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      ks_q    <= ks_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
`ifdef SALSA_CNT_WRAP_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign busy        = (fsm_q != ST_IDLE);
  assign counter_out = cnt_q;
`ifdef SALSA_CNT_WRAP_ERR_EN
  assign cnt_err     = err_q;
`else
  assign cnt_err     = 1'b0;
`endif

endmodule
